// File: rtl/shift_link_pkg.sv
// Shared definitions for the shift-register serial link.
//   rx_state_t : receiver FSM states
//   START_BIT  : line level of a frame start bit
//   STOP_BIT   : line level of a frame stop bit (also the idle level)
package shift_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STOP  = 2'd2,
        BREAK = 2'd3
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/shift_link_sipo.sv
// Serial-in parallel-out shift register with selectable shift direction.
//   clk       : clock
//   rst       : synchronous active-high reset, clears the register
//   clr       : synchronous clear (start of a new frame)
//   en        : shift one bit in this cycle
//   lsb_first : 1 = shift right (bit enters at MSB), 0 = shift left (bit enters at LSB)
//   din       : serial bit to shift in
//   q         : parallel register contents
module shift_link_sipo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              lsb_first,
    input  logic              din,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            // LSB-first: after DATA_W shifts the first bit has travelled to bit 0.
            if (lsb_first) q <= {din, q[DATA_W-1:1]};
            else           q <= {q[DATA_W-2:0], din};
        end
    end

endmodule

// File: rtl/shift_link_rx.sv
// Framed serial receiver: start bit 0, DATA_W data bits, stop bit 1,
// sampled on bit_en ticks, word delivered on a valid/ready port.
//   clk       : clock
//   rst       : synchronous active-high reset
//   bit_en    : one-cycle bit tick; serial_in sampled only when high
//   serial_in : serial line (idles high)
//   lsb_first : bit order for the next frame, captured at the start bit
//   data_out  : received word, stable while valid=1
//   valid     : data_out holds an unconsumed word
//   ready     : consumer accepts the word when valid&&ready
//   busy      : receiver is inside a frame or a line break
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, good word dropped because buffer was full
module shift_link_rx
    import shift_link_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              serial_in,
    input  logic              lsb_first,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ord_q;
    logic [DATA_W-1:0] sh;
    logic              start_hit;
    logic              shift_en;
    logic              stop_ok;
    logic              stop_bad;

    assign start_hit = (state_q == IDLE) && bit_en && (serial_in == START_BIT);
    assign shift_en  = (state_q == DATA) && bit_en;
    assign stop_ok   = (state_q == STOP) && bit_en && (serial_in == STOP_BIT);
    assign stop_bad  = (state_q == STOP) && bit_en && (serial_in != STOP_BIT);

    // busy is decoded from the state register only, so it carries no input path.
    assign busy = (state_q != IDLE);

    shift_link_sipo #(
        .DATA_W(DATA_W)
    ) u_sipo (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_hit),
        .en       (shift_en),
        .lsb_first(ord_q),
        .din      (serial_in),
        .q        (sh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ord_q     <= 1'b0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_hit) begin
                        cnt_q   <= '0;
                        ord_q   <= lsb_first;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_en) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) state_q <= STOP;
                    end
                end
                STOP: begin
                    if (stop_ok) begin
                        state_q <= IDLE;
                    end else if (stop_bad) begin
                        frame_err <= 1'b1;
                        state_q   <= BREAK;
                    end
                end
                BREAK: begin
                    // Stay here while the line is held low so no false start is seen.
                    if (bit_en && serial_in == STOP_BIT) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Output buffer: a delivery on the same cycle as a handshake replaces
            // the consumed word and keeps valid high.
            if (stop_ok) begin
                if (!valid || ready) begin
                    data_out <= sh;
                    valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_link_rx.sv
// Testbench for shift_link_rx with DATA_W=8 and a bit tick every 4 clocks.
module tb_shift_link_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_en;
    logic          serial_in;
    logic          lsb_first;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          ready;
    logic          busy;
    logic          frame_err;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int cyc = 0;

    shift_link_rx #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_en   (bit_en),
        .serial_in(serial_in),
        .lsb_first(lsb_first),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference model: collects bits, builds the word by positional
    // weight, and applies the buffer rules to the resulting word.
    logic          m_in_frame, m_in_break, m_ord;
    int            m_n;
    int            m_word;
    logic          e_valid, e_fe, e_ov, e_busy;
    logic [DW-1:0] e_data;

    always @(posedge clk) begin
        logic deliver;
        logic hs;
        cyc++;
        deliver = 1'b0;
        hs = e_valid && ready;
        e_fe = 1'b0;
        e_ov = 1'b0;
        if (rst) begin
            m_in_frame = 1'b0; m_in_break = 1'b0; m_ord = 1'b0;
            m_n = 0; m_word = 0;
            e_valid = 1'b0; e_data = '0; e_busy = 1'b0;
        end else begin
            if (bit_en) begin
                if (m_in_break) begin
                    if (serial_in) m_in_break = 1'b0;
                end else if (!m_in_frame) begin
                    if (!serial_in) begin
                        m_in_frame = 1'b1; m_n = 0; m_word = 0; m_ord = lsb_first;
                    end
                end else if (m_n < DW) begin
                    if (m_ord) m_word += int'(serial_in) * (1 << m_n);
                    else       m_word += int'(serial_in) * (1 << (DW - 1 - m_n));
                    m_n++;
                end else begin
                    m_in_frame = 1'b0;
                    if (serial_in) deliver = 1'b1;
                    else begin e_fe = 1'b1; m_in_break = 1'b1; end
                end
            end
            if (deliver) begin
                if (!e_valid || ready) begin
                    e_data = DW'(m_word); e_valid = 1'b1;
                end else begin
                    e_ov = 1'b1;
                end
            end else if (hs) begin
                e_valid = 1'b0;
            end
            e_busy = m_in_frame || m_in_break;
        end
    end

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("valid", int'(valid), int'(e_valid));
            chk("busy", int'(busy), int'(e_busy));
            chk("frame_err", int'(frame_err), int'(e_fe));
            chk("overrun", int'(overrun), int'(e_ov));
            if (e_valid) chk("data_out", int'(data_out), int'(e_data));
            if (frame_err === 1'b1) fe_seen++;
            if (overrun === 1'b1) ov_seen++;
        end
    end

    task automatic tick(input logic b, input logic rdy_pulse);
        @(negedge clk);
        serial_in = b; bit_en = 1'b1;
        if (rdy_pulse) ready = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        if (rdy_pulse) ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] w, input logic lsb, input logic stopb,
                        input logic rdy_on_stop);
        lsb_first = lsb;
        tick(1'b0, 1'b0);
        for (int i = 0; i < DW; i++) tick(lsb ? w[i] : w[DW-1-i], 1'b0);
        tick(stopb, rdy_on_stop);
    endtask

    task automatic drain(input string name);
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        chk(name, int'(valid), 0);
    endtask

    initial begin
        int fe0, ov0;
        logic [9:0] line;
        rst = 1'b1; bit_en = 1'b0; serial_in = 1'b1; ready = 1'b0; lsb_first = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", int'(data_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fe", int'(frame_err), 0);
        chk("rst_ov", int'(overrun), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // LSB-first raw line sequence
        line = 10'b1101101010; // bit 0 is sent first
        lsb_first = 1'b1;
        for (int i = 0; i < 10; i++) tick(line[i], 1'b0);
        chk("lsb_data", int'(data_out), 'hB5);
        chk("lsb_valid", int'(valid), 1);
        chk("lsb_fe", int'(frame_err), 0);
        drain("lsb_drain");

        // MSB-first
        send(8'h0D, 1'b0, 1'b1, 1'b0);
        chk("msb_data", int'(data_out), 'h0D);
        chk("msb_valid", int'(valid), 1);
        drain("msb_drain");

        // Framing error then line break
        fe0 = fe_seen;
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        chk("brk_busy", int'(busy), 1);
        tick(1'b1, 1'b0);
        chk("fe_count", fe_seen - fe0, 1);
        chk("fe_valid", int'(valid), 0);
        chk("brk_exit_busy", int'(busy), 0);
        send(8'h3C, 1'b1, 1'b1, 1'b0);
        chk("after_fe_data", int'(data_out), 'h3C);
        drain("after_fe_drain");

        // Overrun
        ov0 = ov_seen;
        send(8'h11, 1'b1, 1'b1, 1'b0);
        send(8'h22, 1'b0, 1'b1, 1'b0);
        chk("ovr_data", int'(data_out), 'h11);
        chk("ovr_count", ov_seen - ov0, 1);
        drain("ovr_drain");

        // Stop bit of second word coincides with handshake of the first
        ov0 = ov_seen;
        send(8'h11, 1'b1, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b1, 1'b1);
        chk("sim_data", int'(data_out), 'h22);
        chk("sim_valid", int'(valid), 1);
        chk("sim_ov", ov_seen - ov0, 0);
        drain("sim_drain");

        // Reset mid-frame
        fe0 = fe_seen;
        lsb_first = 1'b1;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i[0], 1'b0);
        @(negedge clk); rst = 1'b1; serial_in = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mrst_data", int'(data_out), 0);
        chk("mrst_valid", int'(valid), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_fe", fe_seen - fe0, 0);
        send(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("mrst_next_data", int'(data_out), 'h5A);
        chk("mrst_next_valid", int'(valid), 1);
        drain("mrst_drain");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
